regfile_multiport: RTL and testbench

Parametrised successor to the 32x32 two-read/one-write register file.
- Generalised in width and depth.
- Two write ports with fixed priority.
- Optional hardwired zero register and optional write-through bypass.
- Per-register pending scoreboard, so the pipeline can detect reads of registers whose producer has not yet written back.
- Sits between decode (reads, reservations) and writeback (two retire lanes) in the CPU datapath.

---
 rtl/regfile_multiport.sv | 119 +++++++++++
 tb/tb_regfile_multiport.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/regfile_multiport.sv
// rtl/regfile_multiport.sv - parametrised two-read/two-write register file with pending scoreboard
// Lane B overrides lane A on address collisions; a same-edge reserve supersedes a retiring write.
module regfile_multiport #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  output logic [WIDTH-1:0]  ReadData1,
  output logic [WIDTH-1:0]  ReadData2,
  output logic              ReadBusy1,
  output logic              ReadBusy2,
  input  logic [ADDR_W-1:0] WriteRegisterA,
  input  logic [WIDTH-1:0]  WriteDataA,
  input  logic              RegWriteA,
  input  logic [ADDR_W-1:0] WriteRegisterB,
  input  logic [WIDTH-1:0]  WriteDataB,
  input  logic              RegWriteB,
  input  logic              Reserve,
  input  logic [ADDR_W-1:0] ReserveRegister,
  output logic              ReserveStall,
  output logic [ADDR_W:0]   PendingCount
);

  logic [WIDTH-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0] r_pending;
  logic [ADDR_W:0]  r_pending_count;

  logic [DEPTH-1:0] w_wr_hit;
  logic [DEPTH-1:0] w_pending_next;
  logic [ADDR_W:0]  w_pending_count_next;
  logic             w_we_a;
  logic             w_we_b;
  logic             w_zero1;
  logic             w_zero2;
  logic             w_rsv_stall;
  logic             w_rsv_en;

  for (genvar g = 0; g < DEPTH; g++) begin : g_hit
    assign w_wr_hit[g] = (RegWriteA && (WriteRegisterA == ADDR_W'(g))) ||
                         (RegWriteB && (WriteRegisterB == ADDR_W'(g)));
  end

  assign w_we_a  = RegWriteA && !((ZERO_REG != 0) && (WriteRegisterA == '0));
  assign w_we_b  = RegWriteB && !((ZERO_REG != 0) && (WriteRegisterB == '0));
  assign w_zero1 = (ZERO_REG != 0) && (ReadRegister1 == '0);
  assign w_zero2 = (ZERO_REG != 0) && (ReadRegister2 == '0);

  // A retiring write to the reserved register frees it this cycle, so no stall.
  assign w_rsv_stall = Reserve && r_pending[ReserveRegister] && !w_wr_hit[ReserveRegister];
  assign w_rsv_en    = Reserve && !w_rsv_stall &&
                       !((ZERO_REG != 0) && (ReserveRegister == '0));

  always_comb begin
    w_pending_next = r_pending & ~w_wr_hit;
    if (w_rsv_en) begin
      w_pending_next[ReserveRegister] = 1'b1;
    end
    w_pending_count_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_pending_count_next = w_pending_count_next + {{ADDR_W{1'b0}}, w_pending_next[i]};
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
      r_pending       <= '0;
      r_pending_count <= '0;
    end else begin
      if (w_we_a) begin
        r_regs[WriteRegisterA] <= WriteDataA;
      end
      if (w_we_b) begin
        r_regs[WriteRegisterB] <= WriteDataB;
      end
      r_pending       <= w_pending_next;
      r_pending_count <= w_pending_count_next;
    end
  end

  always_comb begin
    ReadData1 = r_regs[ReadRegister1];
    if (w_zero1) begin
      ReadData1 = '0;
    end else if ((BYPASS != 0) && RegWriteB && (WriteRegisterB == ReadRegister1)) begin
      ReadData1 = WriteDataB;
    end else if ((BYPASS != 0) && RegWriteA && (WriteRegisterA == ReadRegister1)) begin
      ReadData1 = WriteDataA;
    end
  end

  always_comb begin
    ReadData2 = r_regs[ReadRegister2];
    if (w_zero2) begin
      ReadData2 = '0;
    end else if ((BYPASS != 0) && RegWriteB && (WriteRegisterB == ReadRegister2)) begin
      ReadData2 = WriteDataB;
    end else if ((BYPASS != 0) && RegWriteA && (WriteRegisterA == ReadRegister2)) begin
      ReadData2 = WriteDataA;
    end
  end

  assign ReadBusy1 = r_pending[ReadRegister1] && !w_zero1 &&
                     !((BYPASS != 0) && w_wr_hit[ReadRegister1]);
  assign ReadBusy2 = r_pending[ReadRegister2] && !w_zero2 &&
                     !((BYPASS != 0) && w_wr_hit[ReadRegister2]);

  assign ReserveStall = w_rsv_stall;
  assign PendingCount = r_pending_count;

endmodule

// File: tb/tb_regfile_multiport.sv
// tb/tb_regfile_multiport.sv - directed bench for regfile_multiport
// d: default build, n: ZERO_REG=0/BYPASS=0 on the same stimulus, s: 16x8 build.
module tb_regfile_multiport;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rr1, rr2, wra, wrb, rsvr;
  logic [31:0] wda, wdb;
  logic        wea, web, rsv;

  logic [31:0] d_rd1, d_rd2, n_rd1, n_rd2;
  logic        d_bz1, d_bz2, n_bz1, n_bz2, d_stall, n_stall;
  logic [5:0]  d_cnt, n_cnt;

  logic [2:0]  s_rr1, s_rr2, s_wra, s_wrb, s_rsvr;
  logic [15:0] s_wda, s_wdb, s_rd1, s_rd2;
  logic        s_wea, s_web, s_rsv, s_bz1, s_bz2, s_stall;
  logic [3:0]  s_cnt;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] exp_v;

  regfile_multiport u_dut_d (
    .Clk(clk), .Rst_n(rst_n),
    .ReadRegister1(rr1), .ReadRegister2(rr2),
    .ReadData1(d_rd1), .ReadData2(d_rd2), .ReadBusy1(d_bz1), .ReadBusy2(d_bz2),
    .WriteRegisterA(wra), .WriteDataA(wda), .RegWriteA(wea),
    .WriteRegisterB(wrb), .WriteDataB(wdb), .RegWriteB(web),
    .Reserve(rsv), .ReserveRegister(rsvr), .ReserveStall(d_stall), .PendingCount(d_cnt)
  );

  regfile_multiport #(.ZERO_REG(0), .BYPASS(0)) u_dut_n (
    .Clk(clk), .Rst_n(rst_n),
    .ReadRegister1(rr1), .ReadRegister2(rr2),
    .ReadData1(n_rd1), .ReadData2(n_rd2), .ReadBusy1(n_bz1), .ReadBusy2(n_bz2),
    .WriteRegisterA(wra), .WriteDataA(wda), .RegWriteA(wea),
    .WriteRegisterB(wrb), .WriteDataB(wdb), .RegWriteB(web),
    .Reserve(rsv), .ReserveRegister(rsvr), .ReserveStall(n_stall), .PendingCount(n_cnt)
  );

  regfile_multiport #(.WIDTH(16), .DEPTH(8), .ADDR_W(3)) u_dut_s (
    .Clk(clk), .Rst_n(rst_n),
    .ReadRegister1(s_rr1), .ReadRegister2(s_rr2),
    .ReadData1(s_rd1), .ReadData2(s_rd2), .ReadBusy1(s_bz1), .ReadBusy2(s_bz2),
    .WriteRegisterA(s_wra), .WriteDataA(s_wda), .RegWriteA(s_wea),
    .WriteRegisterB(s_wrb), .WriteDataB(s_wdb), .RegWriteB(s_web),
    .Reserve(s_rsv), .ReserveRegister(s_rsvr), .ReserveStall(s_stall), .PendingCount(s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wea = 0; web = 0; rsv = 0;
  endtask

  initial begin
    rst_n = 0; rr1 = 0; rr2 = 0; wra = 0; wrb = 0; rsvr = 0;
    wda = 0; wdb = 0; wea = 0; web = 0; rsv = 0;
    s_rr1 = 0; s_rr2 = 0; s_wra = 0; s_wrb = 0; s_rsvr = 0;
    s_wda = 0; s_wdb = 0; s_wea = 0; s_web = 0; s_rsv = 0;
    step(); step();
    rst_n = 1;
    step();

    // reset state
    for (int i = 0; i < 32; i++) begin
      rr1 = 5'(i); rr2 = 5'(i); #1;
      chk("rst_d_rd1", d_rd1, 0); chk("rst_d_rd2", d_rd2, 0);
      chk("rst_n_rd1", n_rd1, 0);
      chk("rst_d_busy", {30'd0, d_bz1, d_bz2}, 0);
    end
    chk("rst_d_cnt", d_cnt, 0); chk("rst_n_cnt", n_cnt, 0);
    chk("rst_s_cnt", s_cnt, 0); chk("rst_stall", d_stall, 0);

    // asynchronous reset mid-run
    wra = 2; wda = 42; wea = 1; step(); idle();
    rr1 = 2; #1;
    chk("r2_written_d", d_rd1, 42); chk("r2_written_n", n_rd1, 42);
    #2 rst_n = 0; #1;
    chk("async_rst_d", d_rd1, 0); chk("async_rst_n", n_rd1, 0);
    #1 rst_n = 1;
    step();

    // dual write collision, B wins
    wra = 5; wda = 15; wea = 1; wrb = 5; wdb = 12; web = 1; step(); idle();
    rr1 = 5; #1;
    chk("collide_d", d_rd1, 12); chk("collide_n", n_rd1, 12);
    wra = 6; wda = 7; wea = 1; wrb = 7; wdb = 9; web = 1; step(); idle();
    for (int i = 0; i < 32; i++) begin
      rr2 = 5'(i); #1;
      exp_v = (i == 5) ? 32'd12 : (i == 6) ? 32'd7 : (i == 7) ? 32'd9 : 32'd0;
      chk("sweep_d", d_rd2, exp_v); chk("sweep_n", n_rd2, exp_v);
    end

    // zero register
    wra = 0; wda = 3; wea = 1; wrb = 0; wdb = 3; web = 1; rsv = 1; rsvr = 0; rr1 = 0; #1;
    chk("zero_rd_pre_d", d_rd1, 0); chk("zero_stall_d", d_stall, 0);
    chk("zero_rd_pre_n", n_rd1, 0);
    step(); idle(); #1;
    chk("zero_rd_d", d_rd1, 0); chk("zero_cnt_d", d_cnt, 0); chk("zero_busy_d", d_bz1, 0);
    chk("zero_rd_n", n_rd1, 3); chk("zero_cnt_n", n_cnt, 1); chk("zero_busy_n", n_bz1, 1);
    wra = 0; wda = 3; wea = 1; step(); idle(); #1;
    chk("zero_clr_cnt_n", n_cnt, 0);

    // bypass
    wra = 4; wda = 18; wea = 1; rr1 = 4; #1;
    chk("bypass_d", d_rd1, 18); chk("nobypass_n", n_rd1, 0);
    wrb = 4; wdb = 2; web = 1; #1;
    chk("bypass_bprio_d", d_rd1, 2);
    web = 0;
    step(); idle(); #1;
    chk("after_wr_d", d_rd1, 18); chk("after_wr_n", n_rd1, 18);

    // scoreboard
    rsv = 1; rsvr = 9; rr1 = 9; #1;
    chk("rsv_nostall", d_stall, 0); chk("rsv_busy_pre", d_bz1, 0);
    step(); idle(); #1;
    chk("rsv_busy_d", d_bz1, 1); chk("rsv_busy_n", n_bz1, 1);
    chk("rsv_cnt_d", d_cnt, 1); chk("rsv_cnt_n", n_cnt, 1);
    rsv = 1; rsvr = 9; #1;
    chk("rsv_stall_d", d_stall, 1); chk("rsv_stall_n", n_stall, 1);
    step(); idle(); #1;
    chk("stall_cnt_d", d_cnt, 1);
    wra = 9; wda = 21; wea = 1; #1;
    chk("wr_busy_bypass_d", d_bz1, 0); chk("wr_busy_nobypass_n", n_bz1, 1);
    step(); idle(); #1;
    chk("clr_busy_d", d_bz1, 0); chk("clr_cnt_d", d_cnt, 0);
    chk("clr_cnt_n", n_cnt, 0); chk("clr_rd_d", d_rd1, 21);
    rsv = 1; rsvr = 9; wrb = 9; wdb = 22; web = 1; step(); idle(); #1;
    chk("rsv_wins_busy_d", d_bz1, 1); chk("rsv_wins_cnt_d", d_cnt, 1);
    chk("rsv_wins_rd_d", d_rd1, 22);
    rsv = 1; rsvr = 9; wra = 9; wda = 23; wea = 1; #1;
    chk("rsv_wr_nostall_d", d_stall, 0);
    step(); idle(); #1;
    chk("rsv_wr_busy_d", d_bz1, 1); chk("rsv_wr_cnt_d", d_cnt, 1);
    rsv = 1; rsvr = 3; step(); idle(); #1;
    chk("two_pending_cnt_d", d_cnt, 2);

    // 16x8 fill and reserve sweep
    for (int i = 1; i < 8; i++) begin
      s_wra = 3'(i); s_wda = 16'(i); s_wea = 1; step();
    end
    s_wea = 0;
    for (int i = 1; i < 8; i++) begin
      s_rsvr = 3'(i); s_rsv = 1; step();
    end
    s_rsv = 0; #1;
    for (int i = 1; i < 8; i++) begin
      s_rr1 = 3'(i); #1;
      chk("fill_rd_s", s_rd1, i); chk("fill_busy_s", s_bz1, 1);
    end
    chk("fill_cnt_s", s_cnt, 7);
    s_rsv = 1; s_rsvr = 0; #1;
    chk("rsv_r0_stall_s", s_stall, 0);
    step(); s_rsv = 0; s_rr1 = 0; #1;
    chk("rsv_r0_cnt_s", s_cnt, 7); chk("rsv_r0_busy_s", s_bz1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
